// File: rtl/i2cc_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C controller between NREQ requesters.
// Optional ownership watchdog enabled with `define ARB_TIMEOUT_EN.
module i2cc_arbiter #(
  parameter int          NREQ    = 2,
  parameter int          DWIDTH  = 8,
  parameter logic [31:0] TIMEOUT = 32'd100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_start,
  input  logic [NREQ-1:0]          req_rdwr,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_txd,
  output logic [DWIDTH-1:0]        req_rxd,
  output logic [NREQ-1:0]          req_done,
  output logic [NREQ-1:0]          req_err,
  output logic [NREQ-1:0]          grant,
  output logic                     i2c_start,
  output logic                     i2c_rdwr,
  output logic                     i2c_last,
  output logic [DWIDTH-1:0]        i2c_addr,
  output logic [DWIDTH-1:0]        i2c_txd,
  input  logic [DWIDTH-1:0]        i2c_rxd,
  input  logic                     i2c_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t                state_r;
  logic [IW-1:0]         rr_ptr_r;
  logic [IW-1:0]         owner_r;
  logic [NREQ-1:0]       pending_r;
  logic                  cap_rdwr_r [NREQ];
  logic                  cap_last_r [NREQ];
  logic [DWIDTH-1:0]     cap_addr_r [NREQ];
  logic [DWIDTH-1:0]     cap_txd_r  [NREQ];
  logic [NREQ-1:0]       grant_r;
  logic [NREQ-1:0]       req_done_r;
  logic [DWIDTH-1:0]     req_rxd_r;
  logic                  i2c_start_r;
  logic                  i2c_rdwr_r;
  logic                  i2c_last_r;
  logic [DWIDTH-1:0]     i2c_addr_r;
  logic [DWIDTH-1:0]     i2c_txd_r;

  logic                  pick_found_s;
  logic [IW-1:0]         pick_idx_s;
  logic [IW-1:0]         cand_s;
  logic                  fwd_s;
  logic [IW-1:0]         fwd_idx_s;
  logic [IW-1:0]         rr_next_s;

  // Round-robin search from rr_ptr upward, plus forward decision for IDLE/HOLD.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {IW{1'b0}};
    cand_s       = {IW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IW'((int'(rr_ptr_r) + k) % NREQ);
      if (!pick_found_s && pending_r[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
    if (state_r == IDLE) begin
      fwd_s     = pick_found_s;
      fwd_idx_s = pick_idx_s;
    end else if (state_r == HOLD) begin
      fwd_s     = pending_r[owner_r];
      fwd_idx_s = owner_r;
    end else begin
      fwd_s     = 1'b0;
      fwd_idx_s = owner_r;
    end
    if (int'(owner_r) == NREQ - 32'sd1) begin
      rr_next_s = {IW{1'b0}};
    end else begin
      rr_next_s = IW'(int'(owner_r) + 32'sd1);
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [31:0]     tmo_r;
  logic [NREQ-1:0] req_err_r;
`else
  logic unused_s;
  assign unused_s = ^TIMEOUT;
`endif

  // Pending capture, arbitration FSM and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {IW{1'b0}};
      owner_r     <= {IW{1'b0}};
      pending_r   <= {NREQ{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
        cap_rdwr_r[i] <= 1'b0;
        cap_last_r[i] <= 1'b0;
        cap_addr_r[i] <= {DWIDTH{1'b0}};
        cap_txd_r[i]  <= {DWIDTH{1'b0}};
      end
      grant_r     <= {NREQ{1'b0}};
      req_done_r  <= {NREQ{1'b0}};
      req_rxd_r   <= {DWIDTH{1'b0}};
      i2c_start_r <= 1'b0;
      i2c_rdwr_r  <= 1'b0;
      i2c_last_r  <= 1'b0;
      i2c_addr_r  <= {DWIDTH{1'b0}};
      i2c_txd_r   <= {DWIDTH{1'b0}};
`ifdef ARB_TIMEOUT_EN
      tmo_r       <= 32'd0;
      req_err_r   <= {NREQ{1'b0}};
`endif
    end else begin
      i2c_start_r <= 1'b0;
      req_done_r  <= {NREQ{1'b0}};
`ifdef ARB_TIMEOUT_EN
      req_err_r   <= {NREQ{1'b0}};
`endif
      // First captured request wins; repeats while pending are dropped.
      for (int i = 0; i < NREQ; i++) begin
        if (req_start[i] && !pending_r[i]) begin
          pending_r[i]  <= 1'b1;
          cap_rdwr_r[i] <= req_rdwr[i];
          cap_last_r[i] <= req_last[i];
          cap_addr_r[i] <= req_addr[i*DWIDTH +: DWIDTH];
          cap_txd_r[i]  <= req_txd[i*DWIDTH +: DWIDTH];
        end
      end
      if (fwd_s) begin
        pending_r[fwd_idx_s] <= 1'b0;
        owner_r     <= fwd_idx_s;
        grant_r     <= {{(NREQ-1){1'b0}}, 1'b1} << fwd_idx_s;
        i2c_start_r <= 1'b1;
        i2c_rdwr_r  <= cap_rdwr_r[fwd_idx_s];
        i2c_last_r  <= cap_last_r[fwd_idx_s];
        i2c_addr_r  <= cap_addr_r[fwd_idx_s];
        i2c_txd_r   <= cap_txd_r[fwd_idx_s];
`ifdef ARB_TIMEOUT_EN
        tmo_r       <= TIMEOUT;
`endif
      end
      case (state_r)
        IDLE: begin
          state_r <= fwd_s ? BUSY : IDLE;
        end
        BUSY: begin
          if (i2c_done) begin
            req_rxd_r           <= i2c_rxd;
            req_done_r[owner_r] <= 1'b1;
            if (i2c_last_r) begin
              grant_r  <= {NREQ{1'b0}};
              rr_ptr_r <= rr_next_s;
              state_r  <= IDLE;
            end else begin
              state_r  <= HOLD;
`ifdef ARB_TIMEOUT_EN
              tmo_r    <= TIMEOUT;
`endif
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_r <= 32'd1) begin
            req_err_r[owner_r] <= 1'b1;
            grant_r  <= {NREQ{1'b0}};
            rr_ptr_r <= rr_next_s;
            state_r  <= IDLE;
          end else begin
            tmo_r <= tmo_r - 32'd1;
          end
`endif
        end
        HOLD: begin
          if (fwd_s) begin
            state_r <= BUSY;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_r <= 32'd1) begin
            req_err_r[owner_r] <= 1'b1;
            grant_r  <= {NREQ{1'b0}};
            rr_ptr_r <= rr_next_s;
            state_r  <= IDLE;
          end else begin
            tmo_r <= tmo_r - 32'd1;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_r;
  assign req_done  = req_done_r;
  assign req_rxd   = req_rxd_r;
  assign i2c_start = i2c_start_r;
  assign i2c_rdwr  = i2c_rdwr_r;
  assign i2c_last  = i2c_last_r;
  assign i2c_addr  = i2c_addr_r;
  assign i2c_txd   = i2c_txd_r;
`ifdef ARB_TIMEOUT_EN
  assign req_err   = req_err_r;
`else
  assign req_err   = {NREQ{1'b0}};
`endif

endmodule

// File: tb/tb_i2cc_arbiter.sv
// Directed bench for i2cc_arbiter (two requesters); timeout section built only with ARB_TIMEOUT_EN.
module tb_i2cc_arbiter;

  localparam int DW = 8;
`ifdef ARB_TIMEOUT_EN
  localparam logic [31:0] TMO = 32'd50;
`else
  localparam logic [31:0] TMO = 32'd100000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_start = 2'b00;
  logic [1:0]    req_rdwr  = 2'b00;
  logic [1:0]    req_last  = 2'b00;
  logic [15:0]   req_addr  = 16'h0000;
  logic [15:0]   req_txd   = 16'h0000;
  logic [7:0]    req_rxd;
  logic [1:0]    req_done;
  logic [1:0]    req_err;
  logic [1:0]    grant;
  logic          i2c_start;
  logic          i2c_rdwr;
  logic          i2c_last;
  logic [7:0]    i2c_addr;
  logic [7:0]    i2c_txd;
  logic [7:0]    i2c_rxd  = 8'h00;
  logic          i2c_done = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  i2cc_arbiter #(.NREQ(2), .DWIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_start(req_start), .req_rdwr(req_rdwr), .req_last(req_last),
    .req_addr(req_addr), .req_txd(req_txd),
    .req_rxd(req_rxd), .req_done(req_done), .req_err(req_err), .grant(grant),
    .i2c_start(i2c_start), .i2c_rdwr(i2c_rdwr), .i2c_last(i2c_last),
    .i2c_addr(i2c_addr), .i2c_txd(i2c_txd),
    .i2c_rxd(i2c_rxd), .i2c_done(i2c_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic rd, input logic lst,
                       input logic [7:0] a, input logic [7:0] d);
    req_start[i] = 1'b1;
    req_rdwr[i]  = rd;
    req_last[i]  = lst;
    req_addr[i*DW +: DW] = a;
    req_txd[i*DW +: DW]  = d;
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (i2c_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(i2c_start), 32'd1);
  endtask

  task automatic done_pulse(input logic [7:0] d);
    i2c_done = 1'b1;
    i2c_rxd  = d;
    tick();
    i2c_done = 1'b0;
    i2c_rxd  = 8'h00;
  endtask

  initial begin
    int n;
    int seen;
    logic [7:0] rx [3];
    logic [7:0] a8;
    rx[0] = 8'hA1; rx[1] = 8'hB2; rx[2] = 8'hC3;

    // Reset state
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_start", 32'(i2c_start), 32'd0);
    chk("rst_done",  32'(req_done), 32'd0);
    chk("rst_err",   32'(req_err), 32'd0);
    chk("rst_addr",  32'(i2c_addr), 32'd0);
    rst = 1'b0;

    // Single requester, 3-byte read
    for (int b = 0; b < 3; b++) begin
      a8 = 8'(8'hD0 + b);
      issue(0, 1'b1, (b == 2), a8, 8'(8'h60 + b));
      tick();
      req_start = 2'b00;
      wait_start("t1_start", n);
      chk("t1_latency", 32'(n), 32'd1);
      chk("t1_addr",  32'(i2c_addr), 32'(a8));
      chk("t1_txd",   32'(i2c_txd), 32'(8'(8'h60 + b)));
      chk("t1_rdwr",  32'(i2c_rdwr), 32'd1);
      chk("t1_last",  32'(i2c_last), (b == 2) ? 32'd1 : 32'd0);
      chk("t1_grant", 32'(grant), 32'd1);
      tick();
      chk("t1_pulse", 32'(i2c_start), 32'd0);
      repeat (8) tick();
      done_pulse(rx[b]);
      chk("t1_done",  32'(req_done), 32'd1);
      chk("t1_rxd",   32'(req_rxd), 32'(rx[b]));
      chk("t1_grant_after", 32'(grant), (b == 2) ? 32'd0 : 32'd1);
      tick();
      chk("t1_done_clr", 32'(req_done), 32'd0);
    end

    // Simultaneous start from reset
    rst = 1'b1; tick(); rst = 1'b0;
    issue(0, 1'b0, 1'b1, 8'h20, 8'h5A);
    issue(1, 1'b1, 1'b1, 8'hF7, 8'h00);
    tick();
    req_start = 2'b00;
    wait_start("t2_start0", n);
    chk("t2_grant0", 32'(grant), 32'd1);
    chk("t2_addr0",  32'(i2c_addr), 32'h20);
    repeat (3) tick();
    done_pulse(8'h11);
    chk("t2_done0", 32'(req_done), 32'd1);
    tick();
    chk("t2_start1", 32'(i2c_start), 32'd1);
    chk("t2_grant1", 32'(grant), 32'd2);
    chk("t2_addr1",  32'(i2c_addr), 32'hF7);
    repeat (3) tick();
    done_pulse(8'h22);
    chk("t2_done1",  32'(req_done), 32'd2);
    chk("t2_rxd1",   32'(req_rxd), 32'h22);
    chk("t2_idle",   32'(grant), 32'd0);

    // Requester 1 arrives while requester 0 holds the bus
    issue(0, 1'b0, 1'b0, 8'h30, 8'h01);
    tick();
    req_start = 2'b00;
    wait_start("t3_start0a", n);
    repeat (2) tick();
    done_pulse(8'h33);
    chk("t3_done0a", 32'(req_done), 32'd1);
    issue(1, 1'b1, 1'b1, 8'h40, 8'h00);
    tick();
    req_start = 2'b00;
    repeat (3) tick();
    chk("t3_hold_grant", 32'(grant), 32'd1);
    chk("t3_hold_start", 32'(i2c_start), 32'd0);
    chk("t3_hold_addr",  32'(i2c_addr), 32'h30);
    issue(0, 1'b0, 1'b1, 8'h31, 8'h02);
    tick();
    req_start = 2'b00;
    wait_start("t3_start0b", n);
    chk("t3_addr0b",  32'(i2c_addr), 32'h31);
    chk("t3_grant0b", 32'(grant), 32'd1);
    repeat (2) tick();
    done_pulse(8'h34);
    chk("t3_grant_rel", 32'(grant), 32'd0);
    tick();
    chk("t3_start1", 32'(i2c_start), 32'd1);
    chk("t3_grant1", 32'(grant), 32'd2);
    chk("t3_addr1",  32'(i2c_addr), 32'h40);
    done_pulse(8'h44);
    chk("t3_done1", 32'(req_done), 32'd2);

    // Back-to-back alternation, 8 transactions each
    issue(0, 1'b0, 1'b1, 8'h80, 8'h7F);
    issue(1, 1'b0, 1'b1, 8'h81, 8'h7E);
    tick();
    req_start = 2'b00;
    for (int it = 0; it < 16; it++) begin
      wait_start("t4_start", n);
      chk("t4_grant", 32'(grant), (it % 2 == 0) ? 32'd1 : 32'd2);
      chk("t4_addr",  32'(i2c_addr), 32'(8'(8'h80 + it)));
      tick();
      if (it < 14) begin
        issue(it % 2, 1'b0, 1'b1, 8'(8'h80 + it + 2), 8'(8'h7F - it - 2));
      end
      done_pulse(8'(it));
      req_start = 2'b00;
      chk("t4_done", 32'(req_done), (it % 2 == 0) ? 32'd1 : 32'd2);
    end
    chk("t4_end_grant", 32'(grant), 32'd0);

    // Reset in BUSY with requester 1 pending
    issue(0, 1'b0, 1'b1, 8'h55, 8'h66);
    tick();
    req_start = 2'b00;
    wait_start("t5_start", n);
    issue(1, 1'b1, 1'b1, 8'h77, 8'h00);
    tick();
    req_start = 2'b00;
    #3 rst = 1'b1;
    #1;
    chk("t5_grant",  32'(grant), 32'd0);
    chk("t5_addr",   32'(i2c_addr), 32'd0);
    chk("t5_txd",    32'(i2c_txd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_pulse(8'h99);
    chk("t5_nodone", 32'(req_done), 32'd0);
    chk("t5_norxd",  32'(req_rxd), 32'd0);
    seen = 0;
    repeat (5) begin
      tick();
      seen = seen | int'(i2c_start) | int'(|grant);
    end
    chk("t5_quiet", 32'(seen), 32'd0);

`ifdef ARB_TIMEOUT_EN
    // Withheld done releases the owner after TIMEOUT cycles
    issue(0, 1'b1, 1'b1, 8'hA0, 8'h00);
    tick();
    req_start = 2'b00;
    wait_start("t6_start0", n);
    issue(1, 1'b1, 1'b1, 8'hB0, 8'h00);
    tick();
    req_start = 2'b00;
    n = 1;
    while (req_err === 2'b00 && n < 200) begin
      tick();
      n++;
    end
    chk("t6_err_delay", 32'(n), 32'd50);
    chk("t6_err",       32'(req_err), 32'd1);
    chk("t6_nodone",    32'(req_done), 32'd0);
    chk("t6_grant_rel", 32'(grant), 32'd0);
    done_pulse(8'hEE);
    chk("t6_late_done", 32'(req_done), 32'd0);
    chk("t6_start1",    32'(i2c_start), 32'd1);
    chk("t6_grant1",    32'(grant), 32'd2);
    chk("t6_addr1",     32'(i2c_addr), 32'hB0);
    done_pulse(8'h5C);
    chk("t6_done1",     32'(req_done), 32'd2);
    chk("t6_rxd1",      32'(req_rxd), 32'h5C);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2cc_arbiter.md
Name: i2cc_arbiter

Overview:
- Shares one byte-level I2C controller port (start/rdwr/last/addr/txd → rxd/done) between NREQ transaction requesters, e.g. the BME280 reader plus a second sensor or config reader.
- Uses round-robin arbitration at transaction granularity. Once a requester is granted, it owns the controller until its byte flagged `last` completes.
- Sits between the requesters and bme280_i2c_ctrl in the 100 MHz domain.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DWIDTH, 8, data/register-address width.
- TIMEOUT, 32'd100000, max cycles between a forwarded start and I2C_done (used only with ARB_TIMEOUT_EN).

Ports:
- Clk  in  1  system clock (100 MHz).
- Rst  in  1  asynchronous, active-high reset.
- Req_start  in  NREQ  per-requester 1-cycle start pulse for one byte operation.
- Req_rdwr  in  NREQ  per-requester read(1)/write(0).
- Req_last  in  NREQ  per-requester last byte of transaction.
- Req_addr  in  NREQ*DWIDTH  per-requester register address, packed, requester i at [i*DWIDTH +: DWIDTH].
- Req_txd  in  NREQ*DWIDTH  per-requester write data, packed.
- Req_rxd  out  DWIDTH  read data, valid when any Req_done bit is set.
- Req_done  out  NREQ  1-cycle completion pulse to the owning requester.
- Req_err  out  NREQ  1-cycle timeout pulse (held 0 without ARB_TIMEOUT_EN).
- Grant  out  NREQ  one-hot current owner, all-zero when idle.
- I2C_start  out  1  start pulse to the controller.
- I2C_rdwr, I2C_last  out  1  registered copies of the owner's request.
- I2C_addr, I2C_txd  out  DWIDTH  registered copies of the owner's request.
- I2C_rxd  in  DWIDTH  controller read data.
- I2C_done  in  1  controller byte-complete pulse.

Behaviour:
- Reset state (asynchronous on Rst): state=IDLE; rr_ptr=0; all pending bits 0; every output 0.
- Pending capture:
  - Each requester has a pending bit plus a registered copy of rdwr/last/addr/txd.
  - Req_start[i] sets pending[i] and captures the fields in the same edge.
  - A Req_start while pending[i] is already set is ignored; the first captured request wins.
- IDLE:
  - If any pending bit is set, pick the first pending requester searching from rr_ptr upward with wrap-around.
  - Grant it, drive its captured fields onto I2C_*, pulse I2C_start for 1 cycle, clear its pending bit, go to BUSY.
  - Requester start at edge N gives I2C_start high in cycle N+1 at the earliest.
- BUSY (waiting for I2C_done):
  - Inputs from non-owners only set their pending bits.
  - On I2C_done: latch I2C_rxd into Req_rxd, pulse Req_done[owner] 1 cycle later, then:
    - if the forwarded byte had last=1: clear Grant, set rr_ptr = owner+1 mod NREQ, go to IDLE.
    - if last=0: go to HOLD.
- HOLD (owner keeps the bus between bytes):
  - Only pending[owner] is served: when it is set, forward it, pulse I2C_start, go to BUSY.
  - Other requesters stay pending.
- Simultaneous events:
  - Req_start[owner] in the same cycle as I2C_done is captured as pending and served on the next HOLD cycle.
  - All requesters starting together in IDLE: the one at or above rr_ptr wins.
- Output timing: Grant updates in the same cycle as I2C_start. I2C_* fields stay stable from I2C_start until the next forward.
- Fairness: worst-case wait is NREQ-1 full transactions.
- Mid-operation Rst: returns immediately to reset state; all pending requests are discarded; no done or err pulse is issued.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A down-counter loads TIMEOUT on every I2C_start and decrements in BUSY.
  - If it reaches 0 before I2C_done: pulse Req_err[owner] for 1 cycle, leave Req_done at 0, clear Grant, advance rr_ptr, go to IDLE.
  - A later stray I2C_done is ignored.
  - The counter also runs in HOLD: an owner silent for TIMEOUT cycles is released the same way.
- Without the macro: no counter exists, Req_err is tied to 0, and ownership is unbounded.

Test Plan:
- Single requester, 3-byte read (last on the 3rd byte), controller done 10 cycles after each start:
  - 3 I2C_start pulses, addr/txd match requester 0.
  - 3 Req_done[0] pulses with Req_rxd = 0xA1, 0xB2, 0xC3.
  - Grant returns to 0 after the 3rd done.
- Req_start[0] and Req_start[1] in the same cycle from reset:
  - Requester 0 is served first.
  - Requester 1's I2C_start follows 1 cycle after requester 0's last done, with requester 1's captured addr 0xF7.
- Requester 1 starts while requester 0 is in HOLD between bytes:
  - Requester 0's 2nd byte is forwarded first.
  - Requester 1 is granted only after requester 0's last byte.
- Back-to-back alternating transactions, 8 of each requester: Grant alternates 01,10,01,…, with no requester served twice in a row while the other is pending.
- Assert Rst while in BUSY with requester 1 pending: all outputs go 0 immediately; after release, a subsequent I2C_done produces no Req_done.
- With ARB_TIMEOUT_EN and TIMEOUT=50, withhold I2C_done:
  - Req_err[0] pulses 50 cycles after I2C_start; no Req_done.
  - Pending requester 1 is granted next; a late I2C_done is ignored.
